// File: rtl/vend_coin_sched.sv
// Coin scheduler in front of vending_machine: two inlet FIFOs, round-robin arbitration,
// one coin per ISSUE cycle followed by a fixed idle gap, plus credit and vend bookkeeping.

module vend_coin_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [1:0] din,
   input  logic       pop,
   output logic [1:0] dout,
   output logic       empty,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [1:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   // Pointers carry one extra lap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

module vend_coin_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYC    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] a_coin,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [1:0] b_coin,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic       hold,
   output logic [1:0] coin_out,
   input  logic       product,
   input  logic       change,
   output logic [4:0] credit,
   output logic [7:0] vend_cnt,
   output logic       err
);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t        state;
   logic [GW-1:0] gap_cnt;
   logic          last_b;
   logic          a_full, a_empty, b_full, b_empty;
   logic [1:0]    a_head, b_head;
   logic          a_xfer, b_xfer, a_push, b_push, a_bad, b_bad;
   logic          grant, pick_b, a_pop, b_pop;
   logic [1:0]    grant_code;
   logic          unused_change;

   // change pulses carry no credit information; the input exists for symmetry with the machine.
   assign unused_change = change;

   function automatic logic [4:0] coin_value(input logic [1:0] code);
      case (code)
         2'b01:   return 5'd5;
         2'b10:   return 5'd10;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] sat_add(input logic [4:0] acc, input logic [4:0] val);
      logic [5:0] sum;
      sum = {1'b0, acc} + {1'b0, val};
      return sum[5] ? 5'd31 : sum[4:0];
   endfunction

   assign a_ready = !a_full;
   assign b_ready = !b_full;
   assign a_xfer  = a_valid & a_ready;
   assign b_xfer  = b_valid & b_ready;
   assign a_push  = a_xfer & ((a_coin == 2'b01) | (a_coin == 2'b10));
   assign b_push  = b_xfer & ((b_coin == 2'b01) | (b_coin == 2'b10));
   assign a_bad   = a_xfer & (a_coin == 2'b11);
   assign b_bad   = b_xfer & (b_coin == 2'b11);

   // Round-robin: with both inlets waiting, the one not granted last goes next.
   assign grant      = (state == IDLE) & !hold & (!a_empty | !b_empty);
   assign pick_b     = !b_empty & (a_empty | !last_b);
   assign a_pop      = grant & !pick_b;
   assign b_pop      = grant & pick_b;
   assign grant_code = pick_b ? b_head : a_head;

   vend_coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
      .clk(clk), .rst(rst), .push(a_push), .din(a_coin), .pop(a_pop),
      .dout(a_head), .empty(a_empty), .full(a_full)
   );

   vend_coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
      .clk(clk), .rst(rst), .push(b_push), .din(b_coin), .pop(b_pop),
      .dout(b_head), .empty(b_empty), .full(b_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         coin_out <= 2'b00;
         gap_cnt  <= '0;
         last_b   <= 1'b1;
         credit   <= 5'd0;
         vend_cnt <= 8'd0;
         err      <= 1'b0;
      end else begin
         err <= a_bad | b_bad;
         if (product && (vend_cnt != 8'hFF)) vend_cnt <= vend_cnt + 8'd1;
         // A product pulse clears credit even if a coin is being added on the same edge.
         if (product)             credit <= 5'd0;
         else if (state == ISSUE) credit <= sat_add(credit, coin_value(coin_out));
         case (state)
            IDLE: begin
               if (grant) begin
                  coin_out <= grant_code;
                  last_b   <= pick_b;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               coin_out <= 2'b00;
               gap_cnt  <= GAP_LOAD;
               state    <= GAP;
            end
            GAP: begin
               if (gap_cnt == '0) state <= IDLE;
               else               gap_cnt <= gap_cnt - GAP_ONE;
            end
            default: begin
               coin_out <= 2'b00;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vend_coin_sched.sv
// Randomised and directed bench for vend_coin_sched with a queue-based reference model
// and a scoreboard monitor that checks every cycle on the falling clock edge.

module tb_vend_coin_sched;
   localparam int DEPTH = 4;
   localparam int GAP   = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] a_coin = 2'b00, b_coin = 2'b00;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       hold = 1'b0, product = 1'b0, change = 1'b0;
   logic       a_ready, b_ready, err;
   logic [1:0] coin_out;
   logic [4:0] credit;
   logic [7:0] vend_cnt;

   always #5 clk = ~clk;

   vend_coin_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst),
      .a_coin(a_coin), .a_valid(a_valid), .a_ready(a_ready),
      .b_coin(b_coin), .b_valid(b_valid), .b_ready(b_ready),
      .hold(hold), .coin_out(coin_out),
      .product(product), .change(change),
      .credit(credit), .vend_cnt(vend_cnt), .err(err)
   );

   typedef struct {
      logic [1:0] code;
      int         cyc;
   } exp_t;

   exp_t       expq[$];
   logic [1:0] qa[$], qb[$];
   int         cyc = 0;
   int         next_grant = 0;
   int         add_edge = -1;
   int         add_val = 0;
   bit         m_last_b = 1'b1;
   int         m_credit = 0;
   int         m_vend = 0;
   bit         m_err = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;

   function automatic int cval(input logic [1:0] c);
      if (c == 2'b01) return 5;
      if (c == 2'b10) return 10;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   // Reference model: coins wait in per-inlet queues; a grant may happen once the previous
   // coin's issue cycle, its gap and one idle cycle have elapsed.
   bit         m_ra, m_rb, m_g, m_pb;
   logic [1:0] m_code;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         qa.delete();
         qb.delete();
         expq.delete();
         next_grant = 0;
         add_edge   = -1;
         add_val    = 0;
         m_last_b   = 1'b1;
         m_credit   = 0;
         m_vend     = 0;
         m_err      = 1'b0;
      end else begin
         cyc++;
         m_ra = (qa.size() < DEPTH);
         m_rb = (qb.size() < DEPTH);
         if (product) m_credit = 0;
         else if (cyc == add_edge) m_credit = (m_credit + add_val > 31) ? 31 : m_credit + add_val;
         if (product && m_vend < 255) m_vend++;
         m_err = (a_valid && m_ra && a_coin == 2'b11) || (b_valid && m_rb && b_coin == 2'b11);
         m_g = (cyc >= next_grant) && !hold && (qa.size() > 0 || qb.size() > 0);
         if (m_g) begin
            m_pb = (qb.size() > 0) && (qa.size() == 0 || !m_last_b);
            m_code = m_pb ? qb.pop_front() : qa.pop_front();
            m_last_b = m_pb;
            expq.push_back('{code: m_code, cyc: cyc});
            add_edge   = cyc + 1;
            add_val    = cval(m_code);
            next_grant = cyc + 2 + GAP;
         end
         if (a_valid && m_ra && (a_coin == 2'b01 || a_coin == 2'b10)) qa.push_back(a_coin);
         if (b_valid && m_rb && (b_coin == 2'b01 || b_coin == 2'b10)) qb.push_back(b_coin);
      end
   end

   exp_t mon_ent;
   always @(negedge clk) begin
      if (rst) begin
         if (coin_out != 2'b00) begin
            if (expq.size() == 0) begin
               check("unexpected_coin", coin_out, 0);
            end else begin
               mon_ent = expq.pop_front();
               check("coin_code", coin_out, mon_ent.code);
               check("coin_cycle", cyc, mon_ent.cyc);
            end
         end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
            check("coin_missing", 0, expq[0].code);
            void'(expq.pop_front());
         end
         check("a_ready", a_ready, qa.size() < DEPTH);
         check("b_ready", b_ready, qb.size() < DEPTH);
         check("credit", credit, m_credit);
         check("vend_cnt", vend_cnt, m_vend);
         check("err", err, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic clear_inputs();
      a_valid = 1'b0; b_valid = 1'b0; a_coin = 2'b00; b_coin = 2'b00;
      hold = 1'b0; product = 1'b0; change = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      idle(2);
      check("rst_coin_out", coin_out, 0);
      check("rst_credit", credit, 0);
      check("rst_vend_cnt", vend_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b1;
      step();
   endtask

   task automatic send_a(input logic [1:0] c);
      bit acc;
      acc = 1'b0;
      a_coin = c;
      a_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         acc = a_ready;
         step();
         if (acc) break;
      end
      if (!acc) check("a_accept_timeout", 0, 1);
      a_valid = 1'b0;
   endtask

   task automatic send_both(input logic [1:0] ca, input logic [1:0] cb);
      check("both_ready_before_send", {a_ready, b_ready}, 2'b11);
      a_coin = ca; b_coin = cb;
      a_valid = 1'b1; b_valid = 1'b1;
      step();
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      hold = 1'b0;
      while ((expq.size() > 0 || qa.size() > 0 || qb.size() > 0 || cyc < next_grant) && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) check("drain_timeout", k, 0);
      idle(4);
   endtask

   initial begin
      int k;
      bit acc;

      // Three back-to-back 5-coins from A, then a product pulse.
      do_reset();
      send_a(2'b01); send_a(2'b01); send_a(2'b01);
      drain();
      check("t1_credit", credit, 15);
      product = 1'b1; step(); product = 1'b0;
      check("t1_credit_clear", credit, 0);
      check("t1_vend", vend_cnt, 1);

      // Simultaneous pushes on both inlets alternate A,B,A,B,...
      do_reset();
      repeat (3) send_both(2'b10, 2'b10);
      drain();
      check("t2_credit_sat", credit, 31);

      // Fill A while held, fifth coin waits on a full FIFO, then release.
      do_reset();
      hold = 1'b1;
      send_a(2'b01); send_a(2'b10); send_a(2'b01); send_a(2'b10);
      check("t3_a_full", a_ready, 0);
      a_coin = 2'b01; a_valid = 1'b1;
      idle(3);
      check("t3_a_still_full", a_ready, 0);
      hold = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 50; i++) begin
         acc = a_ready;
         step();
         if (acc) break;
      end
      if (!acc) check("t3_fifth_timeout", 0, 1);
      a_valid = 1'b0;
      drain();

      // B sends 11, 00, 10: one err pulse, a single 10 coin.
      do_reset();
      b_valid = 1'b1; b_coin = 2'b11; step();
      check("t4_err_pulse", err, 1);
      b_coin = 2'b00; step();
      check("t4_err_once", err, 0);
      b_coin = 2'b10; step();
      b_valid = 1'b0;
      drain();
      check("t4_credit", credit, 10);

      // Reset during ISSUE with two coins still queued.
      do_reset();
      hold = 1'b1;
      send_a(2'b01); send_a(2'b10); send_a(2'b01);
      hold = 1'b0;
      k = 0;
      while (coin_out == 2'b00 && k < 20) begin
         step();
         k++;
      end
      check("t5_coin_seen", coin_out != 2'b00, 1);
      rst = 1'b0;
      #1;
      check("t5_async_coin_out", coin_out, 0);
      idle(2);
      rst = 1'b1;
      idle(20);
      check("t5_credit_after", credit, 0);

      // Vend counter and credit saturation.
      product = 1'b1;
      idle(256);
      product = 1'b0;
      check("t6_vend_sat", vend_cnt, 255);
      repeat (4) send_a(2'b10);
      drain();
      check("t6_credit_sat", credit, 31);

      // Random traffic on both inlets with hold, product and change.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         a_valid = ($urandom_range(0, 99) < 40);
         b_valid = ($urandom_range(0, 99) < 40);
         a_coin  = 2'($urandom_range(0, 3));
         b_coin  = 2'($urandom_range(0, 3));
         hold    = ($urandom_range(0, 99) < 15);
         product = ($urandom_range(0, 99) < 4);
         change  = ($urandom_range(0, 99) < 10);
         step();
      end
      clear_inputs();
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end
endmodule
